// File: rtl/itcm_arbiter.sv
// ITCM arbiter: a UART loader owns the RAM while in BOOT; instruction fetch
// and load/store share it round-robin while in RUN. A one-cycle DRAIN state
// lets the last granted read return its data before control goes back to BOOT.
module itcm_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              boot_mode,
    // instruction fetch port (read only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // load/store port
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    // UART loader port (write only)
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    // ITCM macro side
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    // status
    output logic [15:0]       ld_count,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    // rr = 1 means load/store was granted last, so fetch wins the next contest
    logic              rr;
    logic [15:0]       count;

    // combinational grants, decided in the request cycle
    logic              ld_gnt_c;
    logic              if_gnt_c;
    logic              ls_gnt_c;

    // one-cycle read return tracking (RAM answers one cycle after address)
    logic              if_rvalid_p1;
    logic              ls_rvalid_p1;

    // last address/data driven to the RAM, held while nobody is granted
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] data_hold;

    // Grant decision: loader only in BOOT, round-robin fetch vs load/store in RUN
    always_comb begin
        ld_gnt_c = 1'b0;
        if_gnt_c = 1'b0;
        ls_gnt_c = 1'b0;
        // grants are forced low while reset is held, even though they are combinational
        if (rst_n) begin
            case (state)
                BOOT: begin
                    ld_gnt_c = ld_req;
                end
                RUN: begin
                    if (if_req && ls_req) begin
                        if_gnt_c = rr;
                        ls_gnt_c = ~rr;
                    end else begin
                        if_gnt_c = if_req;
                        ls_gnt_c = ls_req;
                    end
                end
                default: begin
                    // DRAIN: nothing is granted
                end
            endcase
        end
    end

    assign ld_gnt = ld_gnt_c;
    assign if_gnt = if_gnt_c;
    assign ls_gnt = ls_gnt_c;

    // RAM mux: the granted requester drives the macro, otherwise the last value holds.
    // A fetch has no write data, so it leaves ram_data at its held value.
    always_comb begin
        ram_addr = addr_hold;
        ram_data = data_hold;
        if (ld_gnt_c) begin
            ram_addr = ld_addr;
            ram_data = ld_wdata;
        end else if (if_gnt_c) begin
            ram_addr = if_addr;
        end else if (ls_gnt_c) begin
            ram_addr = ls_addr;
            ram_data = ls_wdata;
        end
    end

    assign ram_wren = ld_gnt_c | (ls_gnt_c & ls_we);

    // Hold registers capture whatever was last presented to the RAM
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold <= '0;
            data_hold <= '0;
        end else if (ld_gnt_c || if_gnt_c || ls_gnt_c) begin
            addr_hold <= ram_addr;
            data_hold <= ram_data;
        end
    end

    // Mode FSM with round-robin pointer and saturating loader counter
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            rr    <= 1'b1;
            count <= 16'd0;
        end else begin
            case (state)
                BOOT: begin
                    if (ld_gnt_c && (count != 16'hFFFF)) begin
                        count <= count + 16'd1;
                    end
                    if (!boot_mode) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (if_gnt_c || ls_gnt_c) begin
                        rr <= ls_gnt_c;
                    end
                    if (boot_mode) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // the counter restarts for the next boot load
                    state <= BOOT;
                    count <= 16'd0;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    assign ld_count = count;
    assign state_o  = state;

    // Read-return tracking: a read grant yields exactly one rvalid next cycle
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid_p1 <= 1'b0;
            ls_rvalid_p1 <= 1'b0;
        end else begin
            if_rvalid_p1 <= if_gnt_c;
            ls_rvalid_p1 <= ls_gnt_c & ~ls_we;
        end
    end

    assign if_rvalid = if_rvalid_p1;
    assign ls_rvalid = ls_rvalid_p1;
    // read data is steered from the RAM only in the rvalid cycle, zero otherwise
    assign if_rdata  = if_rvalid_p1 ? ram_q : '0;
    assign ls_rdata  = ls_rvalid_p1 ? ram_q : '0;

endmodule
